// File: rtl/cmlk_imaging_pkg.sv
// Shared definitions for the imaging register bank: AXI response codes,
// FSM state encodings and the default byte-address width helper.
package cmlk_imaging_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_t;

  function automatic int axil_addr_width(input int num_regs, input int data_width);
    return $clog2(num_regs) + $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/cmlk_axil_wr_fsm.sv
// AXI4-Lite write channel handler: accepts AW and W in any order, presents
// one commit strobe with the merged address/data, and returns the response.
//
//   state        | meaning
//   W_IDLE       | waiting for AW and/or W
//   W_HAVE_ADDR  | address captured, waiting for data
//   W_HAVE_DATA  | data captured, waiting for address
//   W_RESP       | write committed, BVALID held until BREADY
module cmlk_axil_wr_fsm
  import cmlk_imaging_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic                      wr_err,
  output logic                      wr_fire,
  output logic [ADDR_WIDTH-1:0]     wr_addr,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic [DATA_WIDTH/8-1:0]   wr_strb
);

  wr_state_t                 state;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]     data_q;
  logic [DATA_WIDTH/8-1:0]   strb_q;
  logic                      aw_hs;
  logic                      w_hs;

  // The commit uses the live bus value when the second handshake is this cycle.
  always_comb begin
    aw_hs   = awvalid & awready;
    w_hs    = wvalid & wready;
    wr_addr = aw_hs ? awaddr : addr_q;
    wr_data = w_hs ? wdata : data_q;
    wr_strb = w_hs ? wstrb : strb_q;
    case (state)
      W_IDLE:      wr_fire = aw_hs & w_hs;
      W_HAVE_ADDR: wr_fire = w_hs;
      W_HAVE_DATA: wr_fire = aw_hs;
      default:     wr_fire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
    end else begin
      if (aw_hs) addr_q <= awaddr;
      if (w_hs) begin
        data_q <= wdata;
        strb_q <= wstrb;
      end
      if (wr_fire) begin
        state   <= W_RESP;
        awready <= 1'b0;
        wready  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else begin
        case (state)
          W_IDLE: begin
            if (aw_hs) begin
              state   <= W_HAVE_ADDR;
              awready <= 1'b0;
              wready  <= 1'b1;
            end else if (w_hs) begin
              state   <= W_HAVE_DATA;
              awready <= 1'b1;
              wready  <= 1'b0;
            end else begin
              awready <= 1'b1;
              wready  <= 1'b1;
            end
          end
          W_HAVE_ADDR: wready  <= 1'b1;
          W_HAVE_DATA: awready <= 1'b1;
          W_RESP: begin
            if (bready) begin
              state   <= W_IDLE;
              bvalid  <= 1'b0;
              awready <= 1'b1;
              wready  <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/cmlk_imaging_regbank.sv
// AXI4-Lite control/status register bank: read/write, read-only status and
// self-clearing pulse registers, with a per-register write strobe.
//
//   state   | meaning
//   R_IDLE  | ARREADY high, waiting for a read address
//   R_RESP  | RDATA/RRESP held until RREADY
module cmlk_imaging_regbank
  import cmlk_imaging_pkg::*;
#(
  parameter int                  C_S_AXI_DATA_WIDTH = 32,
  parameter int                  NUM_REGS           = 16,
  parameter int                  C_S_AXI_ADDR_WIDTH = axil_addr_width(NUM_REGS, C_S_AXI_DATA_WIDTH),
  parameter logic [NUM_REGS-1:0] RO_MASK            = '0,
  parameter logic [NUM_REGS-1:0] PULSE_MASK         = '0
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] ctrl_regs,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS-1:0]                    reg_wr_pulse
);

  localparam int DW   = C_S_AXI_DATA_WIDTH;
  localparam int AW   = C_S_AXI_ADDR_WIDTH;
  localparam int NB   = DW / 8;
  localparam int OFFS = $clog2(NB);
  localparam int IW   = AW - OFFS;

  logic [DW-1:0]       regs_q [NUM_REGS];
  logic                wr_fire;
  logic                wr_err;
  logic [AW-1:0]       wr_addr;
  logic [DW-1:0]       wr_data;
  logic [NB-1:0]       wr_strb;
  logic [IW-1:0]       wr_idx;
  logic [IW-1:0]       rd_idx;
  logic [NUM_REGS-1:0] wr_hit;
  logic [DW-1:0]       rd_data;
  logic                rd_err;
  rd_state_t           rd_state;
  logic                unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[OFFS-1:0], S_AXI_ARADDR[OFFS-1:0], status_in};

  cmlk_axil_wr_fsm #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) u_wr_fsm (
    .clk     (ACLK),
    .rst     (ARESET),
    .awaddr  (S_AXI_AWADDR),
    .awvalid (S_AXI_AWVALID),
    .awready (S_AXI_AWREADY),
    .wdata   (S_AXI_WDATA),
    .wstrb   (S_AXI_WSTRB),
    .wvalid  (S_AXI_WVALID),
    .wready  (S_AXI_WREADY),
    .bresp   (S_AXI_BRESP),
    .bvalid  (S_AXI_BVALID),
    .bready  (S_AXI_BREADY),
    .wr_err  (wr_err),
    .wr_fire (wr_fire),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_strb (wr_strb)
  );

  assign wr_idx = wr_addr[AW-1:OFFS];
  assign rd_idx = S_AXI_ARADDR[AW-1:OFFS];
  assign wr_err = ~|wr_hit;

  // Pulse registers read as zero; out-of-range reads fall through to zero/SLVERR.
  always_comb begin
    wr_hit  = '0;
    rd_data = '0;
    rd_err  = 1'b1;
    for (int n = 0; n < NUM_REGS; n++) begin
      if (int'(wr_idx) == n && !RO_MASK[n]) wr_hit[n] = 1'b1;
      if (int'(rd_idx) == n) begin
        rd_err = 1'b0;
        if (RO_MASK[n]) rd_data = status_in[n*DW +: DW];
        else if (!PULSE_MASK[n]) rd_data = regs_q[n];
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int n = 0; n < NUM_REGS; n++) regs_q[n] <= '0;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= wr_fire ? wr_hit : '0;
      for (int n = 0; n < NUM_REGS; n++) begin
        if (PULSE_MASK[n]) regs_q[n] <= '0;
        if (wr_fire && wr_hit[n]) begin
          for (int k = 0; k < NB; k++)
            if (wr_strb[k]) regs_q[n][8*k +: 8] <= wr_data[8*k +: 8];
        end
      end
    end
  end

  for (genvar n = 0; n < NUM_REGS; n++) begin : g_ctrl
    assign ctrl_regs[n*DW +: DW] = regs_q[n];
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_state      <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            rd_state      <= R_RESP;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b1;
            S_AXI_RDATA   <= rd_data;
            S_AXI_RRESP   <= rd_err ? RESP_SLVERR : RESP_OKAY;
          end else begin
            S_AXI_ARREADY <= 1'b1;
          end
        end
        R_RESP: begin
          if (S_AXI_RREADY) begin
            rd_state      <= R_IDLE;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_ARREADY <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmlk_imaging_regbank.sv
// Scoreboard bench for the imaging register bank: stimulus tasks queue the
// expected responses, a negedge monitor pops and compares them on handshakes.
module tb_cmlk_imaging_regbank;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int AW = 8;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0]    awaddr = '0;
  logic [AW-1:0]    araddr = '0;
  logic [2:0]       awprot = '0;
  logic [2:0]       arprot = '0;
  logic             awvalid = 1'b0;
  logic             wvalid = 1'b0;
  logic             arvalid = 1'b0;
  logic             bready = 1'b1;
  logic             rready = 1'b1;
  logic [DW-1:0]    wdata = '0;
  logic [DW/8-1:0]  wstrb = '0;
  logic [NR*DW-1:0] status_in = '0;
  logic             awready, wready, arready, bvalid, rvalid;
  logic [1:0]       bresp, rresp;
  logic [DW-1:0]    rdata;
  logic [NR*DW-1:0] ctrl_regs;
  logic [NR-1:0]    reg_wr_pulse;

  cmlk_imaging_regbank #(
    .C_S_AXI_DATA_WIDTH (DW),
    .NUM_REGS           (NR),
    .C_S_AXI_ADDR_WIDTH (AW),
    .RO_MASK            (16'h0008),
    .PULSE_MASK         (16'h0010)
  ) dut (
    .ACLK          (clk),
    .ARESET        (rst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .ctrl_regs     (ctrl_regs),
    .status_in     (status_in),
    .reg_wr_pulse  (reg_wr_pulse)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt [NR] = '{default: 0};
  logic [1:0]       exp_b [$];
  logic [1:0]       exp_rr [$];
  logic [DW-1:0]    exp_rd [$];
  logic [NR*DW-1:0] resp_ctrl;
  logic [NR-1:0]    resp_pulse;
  logic [NR*DW-1:0] snap;
  logic             stable, late_b;
  logic [DW-1:0]    hd;
  logic [1:0]       hb, hr;
  int               hcyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] creg(input int n);
    return ctrl_regs[n*DW +: DW];
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      for (int n = 0; n < NR; n++) if (reg_wr_pulse[n]) pulse_cnt[n]++;
      if (bvalid && bready) begin
        if (exp_b.size() == 0) check("b_unexpected_bvalid", 64'(bvalid), 0);
        else check("bresp", 64'(bresp), 64'(exp_b.pop_front()));
      end
      if (rvalid && rready) begin
        if (exp_rd.size() == 0) check("r_unexpected_rvalid", 64'(rvalid), 0);
        else begin
          check("rdata", 64'(rdata), 64'(exp_rd.pop_front()));
          check("rresp", 64'(rresp), 64'(exp_rr.pop_front()));
        end
      end
    end
  end

  // w_lead delays AW by that many cycles after W is presented.
  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [3:0] s, input logic [1:0] er, input int w_lead);
    int   cyc;
    logic aw_go, w_go, aw_done, w_done, early_b, got, seen;
    exp_b.push_back(er);
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; wvalid = 1'b1; awvalid = (w_lead == 0);
    aw_done = 1'b0; w_done = 1'b0; early_b = 1'b0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 100) begin
      @(negedge clk);
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      if (bvalid) early_b = 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (aw_go) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_go) begin wvalid = 1'b0; w_done = 1'b1; end
      if (!aw_done && !awvalid && cyc >= w_lead) awvalid = 1'b1;
    end
    check("aw_w_accepted", 64'(aw_done && w_done), 1);
    check("no_bvalid_before_handshake", 64'(early_b), 0);
    awvalid = 1'b0; wvalid = 1'b0;
    got = 1'b0; seen = 1'b0; cyc = 0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      if (bvalid && !seen) begin
        seen = 1'b1; resp_ctrl = ctrl_regs; resp_pulse = reg_wr_pulse;
      end
      if (bvalid && bready) got = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    check("b_handshake", 64'(got), 1);
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input logic [DW-1:0] ed, input logic [1:0] er);
    int   cyc;
    logic go, done;
    exp_rd.push_back(ed);
    exp_rr.push_back(er);
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    done = 1'b0; cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      go = arready;
      @(posedge clk); #1;
      cyc++;
      if (go) begin arvalid = 1'b0; done = 1'b1; end
    end
    check("ar_accepted", 64'(done), 1);
    arvalid = 1'b0;
    done = 1'b0; cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      if (rvalid && rready) done = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    check("r_handshake", 64'(done), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1);
  end

  initial begin
    status_in[3*DW +: DW] = 32'h4;
    #1;
    check("rst_ready", 64'({awready, wready, arready}), 0);
    check("rst_valid", 64'({bvalid, rvalid, bresp, rresp}), 0);
    check("rst_ctrl_zero", 64'(ctrl_regs == '0), 1);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    check("ready_low_before_edge", 64'({awready, wready, arready}), 0);
    @(posedge clk); #1;
    check("ready_after_edge", 64'({awready, wready, arready}), 3'b111);

    // Basic write/read; register 3 is read-only status returning 0x4 here.
    for (int i = 0; i < 4; i++) axi_write(8'(4*i), 32'(i+1), 4'hF, (i == 3) ? SLVERR : OKAY, 0);
    for (int i = 0; i < 4; i++) axi_read(8'(4*i), 32'(i+1), OKAY);
    for (int i = 0; i < 4; i++) check("pulse_cnt_init", 64'(pulse_cnt[i]), (i == 3) ? 0 : 1);

    axi_write(8'h08, 32'hA5A5A5A5, 4'hF, OKAY, 3);
    check("w_first_pulse", 64'(resp_pulse), 64'h0004);
    check("w_first_reg2", 64'(resp_ctrl[2*DW +: DW]), 64'hA5A5A5A5);
    @(negedge clk);
    check("w_first_pulse_clear", 64'(reg_wr_pulse), 0);

    axi_write(8'h04, 32'h11223344, 4'hF, OKAY, 0);
    axi_write(8'h04, 32'hFFFFFFFF, 4'b0101, OKAY, 0);
    check("strb_reg1", 64'(creg(1)), 64'h11FF33FF);
    axi_read(8'h06, 32'h11FF33FF, OKAY);

    axi_write(8'h00, 32'hFFFFFFFF, 4'h0, OKAY, 0);
    check("strb0_pulse", 64'(resp_pulse), 64'h0001);
    check("strb0_reg0", 64'(creg(0)), 64'h1);

    snap = ctrl_regs;
    axi_write(8'h40, 32'hCAFEF00D, 4'hF, SLVERR, 0);
    check("oor_pulse", 64'(resp_pulse), 0);
    check("oor_no_change", 64'(ctrl_regs == snap), 1);
    axi_read(8'h40, 32'h0, SLVERR);

    status_in[3*DW +: DW] = 32'hDEADBEEF;
    axi_read(8'h0C, 32'hDEADBEEF, OKAY);
    axi_write(8'h0C, 32'h1, 4'hF, SLVERR, 0);
    check("ro_pulse", 64'(resp_pulse), 0);
    check("ro_pulse_cnt3", 64'(pulse_cnt[3]), 0);
    axi_write(8'h10, 32'h5, 4'hF, OKAY, 0);
    check("pulse_reg_set", 64'(resp_ctrl[4*DW +: DW]), 64'h5);
    check("pulse_reg_strobe", 64'(resp_pulse), 64'h0010);
    @(negedge clk);
    check("pulse_reg_clear", 64'(creg(4)), 0);
    axi_read(8'h10, 32'h0, OKAY);

    // Same-cycle read and write of register 0: read sees the old value.
    fork
      axi_write(8'h00, 32'h77, 4'hF, OKAY, 0);
      axi_read(8'h00, 32'h1, OKAY);
    join
    axi_read(8'h00, 32'h77, OKAY);

    bready = 1'b0; rready = 1'b0;
    fork
      axi_write(8'h08, 32'h12345678, 4'hF, OKAY, 0);
      axi_read(8'h04, 32'h11FF33FF, OKAY);
      begin
        hcyc = 0;
        do begin @(negedge clk); hcyc++; end while (!(bvalid && rvalid) && hcyc < 20);
        hb = bresp; hr = rresp; hd = rdata; stable = 1'b1;
        repeat (10) begin
          @(negedge clk);
          if (!(bvalid && rvalid && bresp == hb && rresp == hr && rdata == hd)) stable = 1'b0;
        end
        check("hold_stable", 64'(stable), 1);
        check("hold_rdata", 64'(hd), 64'h11FF33FF);
        @(posedge clk); #1;
        bready = 1'b1; rready = 1'b1;
      end
    join
    check("hold_write_landed", 64'(creg(2)), 64'h12345678);

    @(posedge clk); #1;
    awaddr = 8'h08; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    check("mid_have_addr", 64'({awready, wready}), 2'b01);
    #2 rst = 1'b1; #1;
    check("mid_rst_ready", 64'({awready, wready, arready}), 0);
    check("mid_rst_resp", 64'({bvalid, rvalid, bresp, rresp}), 0);
    check("mid_rst_rdata", 64'(rdata), 0);
    check("mid_rst_ctrl", 64'(ctrl_regs == '0), 1);
    check("mid_rst_pulse", 64'(reg_wr_pulse), 0);
    @(negedge clk); rst = 1'b0; #1;
    check("post_rst_ready_low", 64'({awready, wready, arready}), 0);
    late_b = 1'b0;
    repeat (10) begin @(negedge clk); if (bvalid) late_b = 1'b1; end
    check("no_late_bvalid", 64'(late_b), 0);
    check("post_rst_ready", 64'({awready, wready, arready}), 3'b111);
    axi_write(8'h00, 32'h9, 4'hF, OKAY, 0);
    axi_read(8'h00, 32'h9, OKAY);
    axi_read(8'h08, 32'h0, OKAY);

    repeat (3) @(posedge clk);
    check("b_queue_empty", 64'(exp_b.size()), 0);
    check("r_queue_empty", 64'(exp_rd.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
